// File: rtl/shift_issue_stage.sv
// ============================================================================
// Module      : shift_issue_stage
// Description : Decodes the RV32I shift instructions and issues shifter operands
//               through a two-entry skid buffer; non-shift instructions are dropped.
//               Optional macro SHIFT_ILLEGAL_TRAP_EN enables malformed-encoding trap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [4:0]  out_shamt,
    output logic [1:0]  out_type,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [6:0] c_OP_REG = 7'b0110011;
    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [1:0] c_T_SRL  = 2'b00;
    localparam logic [1:0] c_T_SLL  = 2'b01;
    localparam logic [1:0] c_T_SRA  = 2'b10;
    localparam logic [1:0] c_T_PASS = 2'b11;

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  typ;
        logic [4:0]  rd;
`ifdef SHIFT_ILLEGAL_TRAP_EN
        logic        ill;
`endif
    } entry_t;

    logic   r_v0;
    logic   r_v1;
    logic   r_in_ready;
    entry_t r_e0;
    entry_t r_e1;

    logic       w_op_reg;
    logic       w_op_imm;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_shift;
    logic [1:0] w_type;
    logic       w_illegal;
    entry_t     w_new;
    logic       w_enq;
    logic       w_out_fire;
    logic       w_v0_nxt;
    logic       w_v1_nxt;
    logic       w_ld0_new;
    logic       w_ld0_skid;
    logic       w_ld1;
    logic       w_unused;

    assign w_op_reg = (in_instr[6:0] == c_OP_REG);
    assign w_op_imm = (in_instr[6:0] == c_OP_IMM);
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_is_shift = 1'b0;
        w_type     = c_T_PASS;
        w_illegal  = 1'b0;
        if (w_op_reg || w_op_imm) begin
            if (w_funct3 == 3'b001) begin
                w_is_shift = 1'b1;
                w_type     = c_T_SLL;
`ifdef SHIFT_ILLEGAL_TRAP_EN
                if (w_funct7 != 7'b0000000) begin
                    w_type    = c_T_PASS;
                    w_illegal = 1'b1;
                end
`endif
            end else if (w_funct3 == 3'b101) begin
                w_is_shift = 1'b1;
`ifdef SHIFT_ILLEGAL_TRAP_EN
                case (w_funct7)
                    7'b0000000: w_type = c_T_SRL;
                    7'b0100000: w_type = c_T_SRA;
                    default: begin
                        w_type    = c_T_PASS;
                        w_illegal = 1'b1;
                    end
                endcase
`else
                w_type = in_instr[30] ? c_T_SRA : c_T_SRL;
`endif
            end
        end
    end

    always_comb begin
        w_new       = '0;
        w_new.a     = in_rs1_val;
        w_new.shamt = w_op_reg ? in_rs2_val[4:0] : in_instr[24:20];
        w_new.typ   = w_type;
        w_new.rd    = in_instr[11:7];
`ifdef SHIFT_ILLEGAL_TRAP_EN
        w_new.ill   = w_illegal;
`endif
    end

    assign w_enq      = in_valid && r_in_ready && w_is_shift;
    assign w_out_fire = r_v0 && out_ready;

    // Entry 1 only ever fills when entry 0 is held, so it drains into entry 0 first.
    always_comb begin
        w_v0_nxt   = r_v0;
        w_v1_nxt   = r_v1;
        w_ld0_new  = 1'b0;
        w_ld0_skid = 1'b0;
        w_ld1      = 1'b0;
        if (w_out_fire && r_v1) begin
            w_ld0_skid = 1'b1;
            w_v1_nxt   = w_enq;
            w_ld1      = w_enq;
        end else if (w_out_fire || !r_v0) begin
            w_v0_nxt  = w_enq;
            w_ld0_new = w_enq;
        end else if (w_enq) begin
            w_v1_nxt = 1'b1;
            w_ld1    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_in_ready <= 1'b1;
            r_e0       <= '0;
            r_e0.typ   <= c_T_PASS;
            r_e1       <= '0;
        end else if (flush) begin
            r_v0       <= 1'b0;
            r_v1       <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_v0       <= w_v0_nxt;
            r_v1       <= w_v1_nxt;
            r_in_ready <= !w_v1_nxt;
            if (w_ld0_skid) begin
                r_e0 <= r_e1;
            end else if (w_ld0_new) begin
                r_e0 <= w_new;
            end
            if (w_ld1) begin
                r_e1 <= w_new;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_v0;
    assign out_a     = r_e0.a;
    assign out_shamt = r_e0.shamt;
    assign out_type  = r_e0.typ;
    assign out_rd    = r_e0.rd;
`ifdef SHIFT_ILLEGAL_TRAP_EN
    assign out_illegal = r_e0.ill;
`else
    assign out_illegal = 1'b0;
`endif

    // Operand fields the shifter never needs.
    assign w_unused = &{1'b0, in_instr[19:15], in_rs2_val[31:5], w_funct7, w_illegal};

endmodule

`default_nettype wire

// File: tb/tb_shift_issue_stage.sv
// ============================================================================
// Module      : tb_shift_issue_stage
// Description : Self-checking bench for shift_issue_stage (queue-based model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_issue_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [4:0]  out_shamt;
    logic [1:0]  out_type;
    logic [4:0]  out_rd;
    logic        out_illegal;

    shift_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs1_val (in_rs1_val),
        .in_rs2_val (in_rs2_val),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_shamt  (out_shamt),
        .out_type   (out_type),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic        ill;
    } ent_t;

    ent_t q[$];
    logic m_ready;
    int   checks;
    int   errors;
    int   dut_hs;
    logic chk_en;

    localparam logic [31:0] c_SLLI  = 32'h00309293;
    localparam logic [31:0] c_SRA   = 32'h4020D1B3;
    localparam logic [31:0] c_SRLI  = 32'h00715313;
    localparam logic [31:0] c_SLL   = 32'h004193B3;
    localparam logic [31:0] c_SRAI  = 32'h41F2D413;
    localparam logic [31:0] c_ADD   = 32'h002081B3;
    localparam logic [31:0] c_LH    = 32'h00109083;
    localparam logic [31:0] c_ADDI  = 32'h00108093;
    localparam logic [31:0] c_BADR  = 32'h2030D093;
    localparam logic [31:0] c_BADL  = 32'h02309293;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the ISA shift rules.
    function automatic logic decode(input logic [31:0] ins, input logic [31:0] rs1,
                                    input logic [31:0] rs2, output ent_t e);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e  = '0;
        if (!((op == 7'h33) || (op == 7'h13)) || !((f3 == 3'd1) || (f3 == 3'd5)))
            return 1'b0;
        e.a     = rs1;
        e.shamt = (op == 7'h33) ? rs2[4:0] : ins[24:20];
        e.rd    = ins[11:7];
        e.typ   = (f3 == 3'd1) ? 2'b01 : (ins[30] ? 2'b10 : 2'b00);
`ifdef SHIFT_ILLEGAL_TRAP_EN
        if (((f3 == 3'd1) && (f7 != 7'h00)) || ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20))) begin
            e.typ = 2'b11;
            e.ill = 1'b1;
        end
`else
        if (f7 == 7'h7F) e.ill = 1'b0;
`endif
        return 1'b1;
    endfunction

    initial begin : model
        ent_t e;
        logic sh;
        logic ofire;
        logic ifire;
        m_ready = 1'b1;
        dut_hs  = 0;
        forever begin
            @(posedge clk);
            if (out_valid === 1'b1 && out_ready) dut_hs++;
            if (rst) begin
                q.delete();
                m_ready = 1'b1;
            end else begin
                ofire = (q.size() > 0) && out_ready;
                ifire = in_valid && m_ready;
                sh    = decode(in_instr, in_rs1_val, in_rs2_val, e);
                if (flush) begin
                    q.delete();
                end else begin
                    if (ofire) void'(q.pop_front());
                    if (ifire && sh) q.push_back(e);
                end
                m_ready = (q.size() < 2);
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("valid_ready", 64'({out_valid, in_ready}), 64'({q.size() > 0, m_ready}));
                if (q.size() > 0)
                    check("payload", 64'({out_a, out_shamt, out_type, out_rd, out_illegal}), 64'(q[0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid   = 1'b1;
        in_instr   = ins;
        in_rs1_val = rs1;
        in_rs2_val = rs2;
        tick();
    endtask

    logic [31:0] tbl [0:7];
    int          hs_base;
    logic [31:0] shifted;

    initial begin
        checks = 0; errors = 0; chk_en = 1'b0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_rs1_val = 32'h0; in_rs2_val = 32'h0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        check("rst_fields", 64'({out_a, out_shamt, out_type, out_rd, out_illegal}), 64'({32'h0, 5'd0, 2'b11, 5'd0, 1'b0}));
        rst = 1'b0;
        chk_en = 1'b1;

        // SLLI x5,x1,3
        out_ready = 1'b1;
        put(c_SLLI, 32'h000000F0, 32'h0);
        in_valid = 1'b0;
        check("slli_fields", 64'({out_valid, out_a, out_shamt, out_type, out_rd}), 64'({1'b1, 32'hF0, 5'd3, 2'b01, 5'd5}));

        // SRA replaces the draining SLLI in entry 0
        put(c_SRA, 32'h80000000, 32'hFFFFFFE4);
        in_valid = 1'b0;
        check("sra_fields", 64'({out_valid, out_shamt, out_type, out_rd}), 64'({1'b1, 5'd4, 2'b10, 5'd3}));
        shifted = 32'($signed(out_a) >>> out_shamt);
        check("sra_result", 64'(shifted), 64'hF8000000);
        tick();

        // Stall: SRLI held, SLL skidded, SRAI waits upstream
        out_ready = 1'b0;
        put(c_SRLI, 32'h11111111, 32'h0);
        put(c_SLL, 32'h22222222, 32'h25);
        check("stall_ready", 64'({in_ready, out_rd, out_shamt}), 64'({1'b0, 5'd6, 5'd7}));
        put(c_SRAI, 32'h33333333, 32'h0);
        tick();
        check("stall_hold", 64'({in_ready, out_valid, out_rd}), 64'({1'b0, 1'b1, 5'd6}));
        out_ready = 1'b1;
        tick();
        check("drain_sll", 64'({in_ready, out_rd, out_shamt, out_type}), 64'({1'b1, 5'd7, 5'd5, 2'b01}));
        tick();
        in_valid = 1'b0;
        check("drain_srai", 64'({out_valid, out_rd, out_shamt, out_type}), 64'({1'b1, 5'd8, 5'd31, 2'b10}));
        tick();
        check("drain_empty", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

        // ADD between two SLLs produces no output handshake
        hs_base = dut_hs;
        put(c_SLL, 32'h1, 32'h2);
        put(c_ADD, 32'h5, 32'h6);
        put(c_SLL, 32'h3, 32'h4);
        in_valid = 1'b0;
        tick(); tick();
        check("add_dropped_hs", 64'(dut_hs - hs_base), 64'd2);

        // Flush with both entries full and an input offered
        out_ready = 1'b0;
        put(c_SLL, 32'hA, 32'h1);
        put(c_SLLI, 32'hB, 32'h0);
        flush = 1'b1;
        put(c_SRLI, 32'hC, 32'h0);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_full", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        tick(); tick();
        check("flush_gone", 64'(out_valid), 64'h0);

        // Flush while in_ready=1: the coinciding input is discarded
        put(c_SLL, 32'hD, 32'h1);
        flush = 1'b1;
        put(c_SRAI, 32'hE, 32'h0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_discard", 64'(out_valid), 64'h0);

        // Malformed funct7 encodings
        out_ready = 1'b1;
        put(c_BADR, 32'h77, 32'h0);
        in_valid = 1'b0;
`ifdef SHIFT_ILLEGAL_TRAP_EN
        check("bad_srli", 64'({out_valid, out_type, out_illegal}), 64'({1'b1, 2'b11, 1'b1}));
`else
        check("bad_srli", 64'({out_valid, out_type, out_illegal}), 64'({1'b1, 2'b00, 1'b0}));
`endif
        put(c_BADL, 32'h78, 32'h0);
        in_valid = 1'b0;
`ifdef SHIFT_ILLEGAL_TRAP_EN
        check("bad_slli", 64'({out_valid, out_type, out_illegal}), 64'({1'b1, 2'b11, 1'b1}));
`else
        check("bad_slli", 64'({out_valid, out_type, out_illegal}), 64'({1'b1, 2'b01, 1'b0}));
`endif
        tick();

        // Mixed traffic with irregular backpressure and a mid-stream flush
        tbl[0] = c_SLLI; tbl[1] = c_LH;  tbl[2] = c_SRA;  tbl[3] = c_ADDI;
        tbl[4] = c_SRLI; tbl[5] = c_SLL; tbl[6] = c_BADR; tbl[7] = c_SRAI;
        for (int i = 0; i < 48; i++) begin
            out_ready  = ((i % 3) != 0) && ((i % 7) != 5);
            flush      = (i == 20) || (i == 37);
            in_valid   = ((i % 5) != 4);
            in_instr   = tbl[(i * 3) % 8];
            in_rs1_val = 32'h1000_0000 + 32'(i * 17);
            in_rs2_val = 32'(i * 7);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        // Reset mid-transfer discards buffered entries
        out_ready = 1'b0;
        put(c_SLL, 32'h9, 32'h1);
        put(c_SRLI, 32'h8, 32'h0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid", 64'({out_valid, in_ready, out_type}), 64'({1'b0, 1'b1, 2'b11}));
        tick(); tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
